// File: rtl/sa2x2_seq_pkg.sv
// rtl/sa2x2_seq_pkg.sv - Shared state encoding and defaults for systolic array sequencers
//
// Contents:
//   seq_state_e  : job sequencer states (IDLE, CLEAR, FEED, DRAIN, DONE)
//   SA_DRAIN_CYC : default cycles from the last skewed beat to a stable array sum
//   SA_LEN_W     : default width of the job length and beat counter
package sa2x2_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  localparam int SA_DRAIN_CYC = 3;
  localparam int SA_LEN_W     = 8;

endpackage

// File: rtl/sa_skew_reg.sv
// rtl/sa_skew_reg.sv - Two-lane 8-bit single-stage delay line for array input skew
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   d_in0, d_in1     : lane inputs, captured every cycle
//   d_out0, d_out1   : lane inputs delayed by one cycle
module sa_skew_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d_in0,
  input  logic [7:0] d_in1,
  output logic [7:0] d_out0,
  output logic [7:0] d_out1
);

  always_ff @(posedge clk) begin
    if (rst) begin
      d_out0 <= 8'd0;
      d_out1 <= 8'd0;
    end else begin
      d_out0 <= d_in0;
      d_out1 <= d_in1;
    end
  end

endmodule

// File: rtl/sa2x2_seq.sv
// rtl/sa2x2_seq.sv - Job sequencer feeding a 2x2 systolic MAC array
//
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   start, cfg_len                   : job request and beat count (accepted in IDLE only)
//   busy                             : high whenever a job is in progress
//   in_valid, in_ready               : operand beat handshake
//   in_d0, in_d1, in_w0, in_w1       : operand beat (two data lanes, two weight lanes)
//   sa_din0, sa_din1, sa_win0, sa_win1 : registered, skewed drive to the array
//   sa_clear                         : array accumulator clear
//   sa_out                           : array sum
//   res_valid, res_ready, res_data   : result handshake and captured sum
module sa2x2_seq
  import sa2x2_seq_pkg::*;
#(
  parameter int DRAIN_CYC = SA_DRAIN_CYC,
  parameter int LEN_W     = SA_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_d0,
  input  logic [7:0]       in_d1,
  input  logic [7:0]       in_w0,
  input  logic [7:0]       in_w1,
  output logic [7:0]       sa_din0,
  output logic [7:0]       sa_din1,
  output logic [7:0]       sa_win0,
  output logic [7:0]       sa_win1,
  output logic             sa_clear,
  input  logic [7:0]       sa_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data
);

  // Wide enough to hold DRAIN_CYC, and never zero width even when DRAIN_CYC is 0.
  localparam int DCNT_W = $clog2(DRAIN_CYC + 2);

  seq_state_e        state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_cnt;
  logic [DCNT_W-1:0] drain_cnt;
  logic              beat;
  logic [7:0]        skew_d_in;
  logic [7:0]        skew_w_in;
  logic [7:0]        skew_d_q;
  logic [7:0]        skew_w_q;

  // in_ready is a registered copy of "state is FEED", so it doubles as the FEED qualifier.
  assign beat = in_valid && in_ready;

  // Lane 1 enters the skew stage only on a beat; bubbles shift zeros through.
  assign skew_d_in = beat ? in_d1 : 8'd0;
  assign skew_w_in = beat ? in_w1 : 8'd0;

  sa_skew_reg u_skew (
    .clk    (clk),
    .rst    (rst),
    .d_in0  (skew_d_in),
    .d_in1  (skew_w_in),
    .d_out0 (skew_d_q),
    .d_out1 (skew_w_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      sa_din0   <= 8'd0;
      sa_win0   <= 8'd0;
      sa_din1   <= 8'd0;
      sa_win1   <= 8'd0;
      sa_clear  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= 8'd0;
    end else begin
      // Lane 0 is zero unless a beat lands this cycle; lane 1 always follows the skew stage
      // (the second half of the one-cycle lag between lanes).
      sa_din0  <= 8'd0;
      sa_win0  <= 8'd0;
      sa_din1  <= skew_d_q;
      sa_win1  <= skew_w_q;
      sa_clear <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start && (cfg_len != '0)) begin
            len_q    <= cfg_len;
            busy     <= 1'b1;
            sa_clear <= 1'b1;
            state    <= ST_CLEAR;
          end
        end

        ST_CLEAR: begin
          beat_cnt <= '0;
          in_ready <= 1'b1;
          state    <= ST_FEED;
        end

        ST_FEED: begin
          if (beat) begin
            sa_din0  <= in_d0;
            sa_win0  <= in_w0;
            beat_cnt <= beat_cnt + LEN_W'(1);
            if ((beat_cnt + LEN_W'(1)) == len_q) begin
              in_ready  <= 1'b0;
              drain_cnt <= '0;
              state     <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          // 1 + DRAIN_CYC cycles: one to flush the skew stage, then the array latency.
          drain_cnt <= drain_cnt + DCNT_W'(1);
          if (drain_cnt == DCNT_W'(DRAIN_CYC)) begin
            res_data  <= sa_out;
            res_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          res_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
